// File: rtl/tape_mem_arbiter.sv
// Shares one SDRAM command port between a buffered download write stream and cassette reads.
// Writes win by default; a pending read is forced through after STARVE_LIMIT consecutive writes.
module tape_mem_arbiter #(
  parameter int WFIFO_DEPTH  = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT      = 63
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        dl_active,
  input  logic        rd_req,
  input  logic [24:0] rd_addr,
  output logic        rd_ack,
  output logic [7:0]  rd_data,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [7:0]  mem_dout,
  input  logic        mem_ready,
  output logic        wfifo_ovf,
  output logic        mem_timeout
);
  // state    | meaning
  // IDLE     | arbitrate between FIFO head and pending read
  // WR_ISSUE | mem_we pulse from FIFO head, head popped
  // RD_ISSUE | mem_rd pulse with rd_addr
  // WAIT     | command outstanding until mem_ready or timeout
  typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, WAIT} state_t;

  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [32:0]   fifo_mem [WFIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [24:0]   addr_q, addr_d;
  logic [7:0]    din_q, din_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_ack_q, rd_ack_d;
  logic          ovf_q, ovf_d;
  logic          tmo_flag_q, tmo_flag_d;
  logic          is_rd_q, is_rd_d;
  logic          start_q;
  logic          fifo_full, fifo_empty, push, pop, tmo_hit;
  logic [32:0]   head;

  assign fifo_full  = (cnt_q == CW'(WFIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign pop        = (state_q == WR_ISSUE);
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push       = dl_wr && (!fifo_full || pop);
  assign head       = fifo_mem[rptr_q];
  assign tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= {dl_addr, dl_data};
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q | (dl_wr & fifo_full & ~pop);
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // start_q holds off arbitration for the first cycle after reset release
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_q) begin
          if (!fifo_empty && (!rd_req || dl_active || starve_q < SW'(STARVE_LIMIT)))
            state_d = WR_ISSUE;
          else if (rd_req && !dl_active)
            state_d = RD_ISSUE;
        end
      end
      WR_ISSUE, RD_ISSUE: state_d = WAIT;
      WAIT:               if (mem_ready || tmo_hit) state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_rd   = 1'b0;
    mem_addr = addr_q;
    mem_din  = din_q;
    case (state_q)
      WR_ISSUE: begin
        mem_we   = 1'b1;
        mem_addr = head[32:8];
        mem_din  = head[7:0];
      end
      RD_ISSUE: begin
        mem_rd   = 1'b1;
        mem_addr = rd_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    addr_d     = mem_addr;
    din_d      = mem_din;
    starve_d   = starve_q;
    tmo_d      = '0;
    is_rd_d    = is_rd_q;
    rd_ack_d   = 1'b0;
    rd_data_d  = rd_data_q;
    tmo_flag_d = tmo_flag_q;
    case (state_q)
      IDLE: if (fifo_empty) starve_d = '0;
      WR_ISSUE: begin
        is_rd_d = 1'b0;
        if (starve_q < SW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
      end
      RD_ISSUE: begin
        is_rd_d  = 1'b1;
        starve_d = '0;
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (mem_ready) begin
          tmo_d = '0;
          if (is_rd_q) begin
            rd_ack_d  = 1'b1;
            rd_data_d = mem_dout;
          end
        end else if (tmo_hit) begin
          tmo_d      = '0;
          tmo_flag_d = 1'b1;
          if (is_rd_q) begin
            rd_ack_d  = 1'b1;
            rd_data_d = 8'hFF;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      starve_q   <= '0;
      tmo_q      <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      is_rd_q    <= 1'b0;
      rd_ack_q   <= 1'b0;
      rd_data_q  <= '0;
      tmo_flag_q <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      starve_q   <= starve_d;
      tmo_q      <= tmo_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      is_rd_q    <= is_rd_d;
      rd_ack_q   <= rd_ack_d;
      rd_data_q  <= rd_data_d;
      tmo_flag_q <= tmo_flag_d;
      start_q    <= 1'b1;
    end
  end

  assign rd_ack      = rd_ack_q;
  assign rd_data     = rd_data_q;
  assign wfifo_ovf   = ovf_q;
  assign mem_timeout = tmo_flag_q;

endmodule

// File: tb/tb_tape_mem_arbiter.sv
// Directed bench for tape_mem_arbiter: a negedge monitor logs commands/acks and plays the
// SDRAM controller with a programmable response delay; the main sequence checks timing and order.
module tb_tape_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dl_wr = 1'b0, dl_active = 1'b0, rd_req = 1'b0, mem_ready = 1'b0;
  logic [24:0] dl_addr = '0, rd_addr = '0;
  logic [7:0]  dl_data = '0, mem_dout = '0;
  logic        rd_ack, mem_we, mem_rd, wfifo_ovf, mem_timeout;
  logic [7:0]  rd_data, mem_din;
  logic [24:0] mem_addr;

  tape_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_active(dl_active),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_dout(mem_dout), .mem_ready(mem_ready),
    .wfifo_ovf(wfifo_ovf), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0, n_err = 0;
  int          we_cnt = 0, rd_cnt = 0, ack_cnt = 0, both_cnt = 0;
  int          last_rd_cyc = 0, last_ack_cyc = 0;
  logic [24:0] last_rd_addr = '0;
  logic [7:0]  last_ack_data = '0;
  logic [32:0] wr_log[$];
  bit          cmd_log[$];   // 0 = write, 1 = read
  int          resp_cnt = 0, resp_dly = 2;
  bit          resp_en = 1'b1;
  logic [7:0]  resp_data = '0;

  initial forever begin
    @(negedge clk);
    if (mem_we) begin
      we_cnt++;
      wr_log.push_back({mem_addr, mem_din});
      cmd_log.push_back(1'b0);
    end
    if (mem_rd) begin
      rd_cnt++;
      last_rd_cyc  = cyc;
      last_rd_addr = mem_addr;
      cmd_log.push_back(1'b1);
    end
    if (mem_we && mem_rd) both_cnt++;
    if (rd_ack) begin
      ack_cnt++;
      last_ack_cyc  = cyc;
      last_ack_data = rd_data;
    end
    mem_ready = 1'b0;
    if (mem_we || mem_rd) resp_cnt = resp_dly;
    else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0 && resp_en) begin
        mem_ready = 1'b1;
        mem_dout  = resp_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rd(input int base, input int budget);
    int n = 0;
    while (rd_cnt <= base && n < budget) begin
      tick();
      n++;
    end
    check_eq("mem_rd_seen", rd_cnt > base, 1);
  endtask

  task automatic wait_ack(input int base, input int budget);
    int n = 0;
    while (ack_cnt <= base && n < budget) begin
      tick();
      n++;
    end
    rd_req = 1'b0;
    check_eq("rd_ack_seen", ack_cnt > base, 1);
  endtask

  int          rb, ab, wb, lb, cb, t0, nw, idx, next_kind;
  bit          raised, dropped, found;
  logic [32:0] exp_wr;

  initial begin
    // reset state
    repeat (3) tick();
    check_eq("rst_we_rd", {mem_we, mem_rd}, 2'b00);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_din", mem_din, 0);
    check_eq("rst_ack_data", {rd_ack, rd_data}, 0);
    check_eq("rst_flags", {wfifo_ovf, mem_timeout}, 2'b00);
    reset_n = 1'b1;
    repeat (3) tick();

    // idle read
    resp_dly = 3; resp_data = 8'h5A; rd_addr = 25'h000123;
    rb = rd_cnt; ab = ack_cnt;
    rd_req = 1'b1; t0 = cyc;
    wait_rd(rb, 10);
    check_eq("rd_latency", last_rd_cyc - t0, 1);
    check_eq("rd_addr", last_rd_addr, 25'h000123);
    wait_ack(ab, 20);
    check_eq("ack_latency", last_ack_cyc - last_rd_cyc, 4);
    check_eq("rd_data", rd_data, 8'h5A);
    repeat (3) tick();
    check_eq("rd_data_hold", rd_data, 8'h5A);
    check_eq("ack_single", ack_cnt - ab, 1);

    // burst of 5 writes while a read is outstanding: 5th overflows a 4-deep FIFO
    resp_dly = 8; resp_data = 8'hC3; rd_addr = 25'h000200;
    wb = we_cnt; lb = wr_log.size(); rb = rd_cnt; ab = ack_cnt;
    rd_req = 1'b1;
    wait_rd(rb, 10);
    check_eq("ovf_pre", wfifo_ovf, 0);
    for (int i = 0; i < 5; i++) begin
      dl_wr = 1'b1; dl_addr = 25'(32'h1000 + i); dl_data = 8'(8'h10 + i);
      tick();
    end
    dl_wr = 1'b0; resp_dly = 2;
    check_eq("ovf_set", wfifo_ovf, 1);
    wait_ack(ab, 20);
    check_eq("ovf_rd_data", rd_data, 8'hC3);
    repeat (30) tick();
    check_eq("ovf_wr_cnt", we_cnt - wb, 4);
    for (int i = 0; i < 4; i++) begin
      exp_wr = {25'(32'h1000 + i), 8'(8'h10 + i)};
      check_eq("ovf_wr_order", (lb + i < wr_log.size()) ? wr_log[lb + i] : 33'h0, exp_wr);
    end

    // starvation guard
    resp_dly = 4; resp_data = 8'h77; rd_addr = 25'h000300;
    wb = we_cnt; cb = cmd_log.size(); ab = ack_cnt;
    raised = 1'b0; dropped = 1'b0;
    for (int i = 0; i < 60; i++) begin
      dl_wr = (i % 3 == 0); dl_addr = 25'(32'h2000 + i); dl_data = 8'(i);
      if (!raised && we_cnt > wb) begin rd_req = 1'b1; raised = 1'b1; end
      if (raised && !dropped && ack_cnt > ab) begin rd_req = 1'b0; dropped = 1'b1; end
      tick();
    end
    dl_wr = 1'b0;
    if (!dropped) wait_ack(ab, 40);
    repeat (60) tick();
    nw = 0; found = 1'b0; next_kind = 2; idx = cb;
    while (idx < cmd_log.size() && !found) begin
      if (cmd_log[idx]) found = 1'b1;
      else nw++;
      idx++;
    end
    if (found && idx < cmd_log.size()) next_kind = int'(cmd_log[idx]);
    check_eq("starve_writes", nw, 8);
    check_eq("starve_resume", next_kind, 0);
    check_eq("starve_ack_data", last_ack_data, 8'h77);

    // download lockout
    resp_dly = 2; resp_data = 8'h3C; rd_addr = 25'h000400;
    rb = rd_cnt; ab = ack_cnt;
    dl_active = 1'b1; rd_req = 1'b1;
    repeat (20) tick();
    check_eq("lockout_no_rd", rd_cnt - rb, 0);
    dl_active = 1'b0; t0 = cyc;
    wait_rd(rb, 10);
    check_eq("lockout_release_lat", last_rd_cyc - t0, 1);
    wait_ack(ab, 20);
    check_eq("lockout_data", rd_data, 8'h3C);

    // read timeout
    check_eq("tmo_pre", mem_timeout, 0);
    resp_en = 1'b0; rd_addr = 25'h000500;
    rb = rd_cnt; ab = ack_cnt;
    rd_req = 1'b1;
    wait_rd(rb, 10);
    wait_ack(ab, 100);
    check_eq("tmo_latency", last_ack_cyc - last_rd_cyc, 64);
    check_eq("tmo_data", rd_data, 8'hFF);
    check_eq("tmo_flag", mem_timeout, 1);
    resp_en = 1'b1;
    repeat (3) tick();

    // reset while a read waits; the late mem_ready lands in IDLE and must be ignored
    resp_dly = 10; resp_data = 8'h99; rd_addr = 25'h000600;
    rb = rd_cnt; ab = ack_cnt;
    rd_req = 1'b1;
    wait_rd(rb, 10);
    repeat (2) tick();
    reset_n = 1'b0; rd_req = 1'b0;
    repeat (2) tick();
    check_eq("wrst_we_rd_ack", {mem_we, mem_rd, rd_ack}, 3'b000);
    check_eq("wrst_mem_addr", mem_addr, 0);
    check_eq("wrst_mem_din", mem_din, 0);
    check_eq("wrst_rd_data", rd_data, 0);
    check_eq("wrst_flags", {wfifo_ovf, mem_timeout}, 2'b00);
    reset_n = 1'b1; rb = rd_cnt;
    repeat (15) tick();
    check_eq("wrst_no_ack", ack_cnt - ab, 0);
    check_eq("wrst_no_rd", rd_cnt - rb, 0);

    // first command after reset release
    reset_n = 1'b0; resp_dly = 2; resp_data = 8'h42; rd_addr = 25'h000700;
    repeat (2) tick();
    rd_req = 1'b1;
    tick();
    rb = rd_cnt; ab = ack_cnt;
    reset_n = 1'b1; t0 = cyc;
    wait_rd(rb, 10);
    check_eq("startup_gap_ge2", (last_rd_cyc - t0) >= 2, 1);
    wait_ack(ab, 20);
    check_eq("startup_data", rd_data, 8'h42);

    check_eq("never_we_and_rd", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
